mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single CPU memory port (mem_address/datasize/read/write/done) among three requesters.
//  Requesters: 0 = instruction fetch unit, 1 = exec unit (load/store), 2 = debug/loader port.
//  Replaces the stage-based fetch/exec mux in the cpu top.
//  Allows exactly one outstanding transaction, selected by rotating priority.
//  Includes a bus watchdog that aborts hung transactions and flags a bus error to the trap logic.
// PARAMETERS
//  TIMEOUT   255   cycles in BUSY without mem_done before abort (1..65535)
//  RESET_PRI 1     index of the requester holding highest priority after reset
// PORTS
//  clk            in   1      clock
//  reset_n        in   1      asynchronous, active-low reset
//  req_valid      in   3      per-requester request; held until req_done/req_err
//  req_addr       in   3x64   per-requester byte address
//  req_size       in   3x2    0 byte, 1 wyde, 2 tetra, 3 octa
//  req_write      in   3      1 = store, 0 = load
//  req_wdata      in   3x64   store data, right-justified
//  req_done       out  3      one-cycle completion pulse to the granted requester
//  req_err        out  3      one-cycle abort pulse (watchdog) to the granted requester
//  rdata          out  64     load data; valid only in the req_done cycle
//  grant_id       out  2      current/last grant index (debug LEDs)
//  busy           out  1      transaction in flight
//  mem_address    out  64     to memory; low bits forced to 0 per size (aligned)
//  mem_datasize   out  2      to memory
//  mem_read       out  1      read strobe, held until mem_done
//  mem_write      out  1      write strobe, held until mem_done
//  mem_writedata  out  64     to memory
//  mem_readdata   in   64     from memory
//  mem_done       in   1      one-cycle completion from memory
//  bus_err        out  1      sticky watchdog flag (feeds rQ/interrupt logic)
//  bus_err_clr    in   1      synchronous clear of bus_err
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; priority pointer = RESET_PRI; wdog = 0.
//  Reset is asynchronous. Assertion mid-transaction drops mem_read/mem_write immediately; no done or err pulse is issued.
//  States: IDLE, BUSY.
//  IDLE:
//   - If any req_valid is set, pick the first set bit scanning from ptr, ptr+1, ptr+2 (mod 3).
//   - Register grant_id, the aligned address (addr & ~((1<<size)-1)), size, wdata and write.
//   - Drive mem_read = ~write or mem_write = write from the next cycle. Go to BUSY. Clear wdog.
//  BUSY:
//   - Outputs stay stable; requester inputs are ignored after the grant.
//   - wdog increments each cycle.
//   - On mem_done: req_done[grant_id] = 1 combinationally in the same cycle.
//     rdata = mem_readdata, passed through, zero outside the done cycle.
//     Strobes drop next cycle. ptr <= (grant_id+1) mod 3. Go to IDLE.
//   - On wdog == TIMEOUT-1 without mem_done: req_err[grant_id] pulses; bus_err <= 1.
//     Strobes drop next cycle. ptr advances. Go to IDLE.
//   - mem_done in the same cycle as timeout: done wins, no err, bus_err unchanged.
//  Latency: req_valid seen in cycle N -> strobe high in N+1 -> done in the mem_done cycle.
//   Minimum back-to-back issue spacing is 2 cycles (one IDLE cycle between transactions).
//  Requesters drop req_valid in the cycle after req_done/req_err.
//   A req_valid still high in IDLE is a new request.
//  bus_err_clr together with a new timeout in the same cycle: set wins.
//  mem_done while in IDLE is ignored. Exactly one of mem_read/mem_write may be high; never both.
// TESTING
//  1. Single fetch: req0, addr 0x8000_0000_0000_0003, size 2, mem_done after 3 cycles
//     -> mem_address ...0000, mem_read 3 cycles, req_done[0] pulse, rdata = mem_readdata.
//  2. Simultaneous req0+req1 after reset (ptr=1)
//     -> exec served first, then fetch; grant order 1,0; no overlap of strobes.
//  3. All three held continuously, mem_done after 1 cycle
//     -> grant order rotates 1,2,0,1,2,0; each requester served once per 3 transactions.
//  4. Store size 3 with addr 0x...07, wdata 0xDEADBEEF_CAFEF00D
//     -> mem_address ...00, mem_write=1, mem_read=0, writedata unchanged.
//  5. Memory never acks, TIMEOUT=8
//     -> req_err pulse 8 cycles after strobe rise, bus_err=1 until bus_err_clr; next request still serviced.
//  6. reset_n low mid-BUSY
//     -> strobes 0 same cycle; after release, state IDLE, ptr=RESET_PRI, no done pulse.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the single CPU memory port among the fetch (0), exec (1)
// and debug/loader (2) requesters. One transaction at a time, rotating priority,
// with a watchdog that aborts transactions the memory never acknowledges.
module mem_bus_arbiter #(
    parameter  int unsigned TIMEOUT   = 255,
    parameter  int unsigned RESET_PRI = 1,
    localparam int unsigned N_REQ     = 3,
    localparam int unsigned AW        = 64,
    localparam int unsigned DW        = 64,
    localparam int unsigned WDW       = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [N_REQ-1:0]        i_req_valid,
    input  logic [N_REQ-1:0][AW-1:0] i_req_addr,
    input  logic [N_REQ-1:0][1:0]   i_req_size,
    input  logic [N_REQ-1:0]        i_req_write,
    input  logic [N_REQ-1:0][DW-1:0] i_req_wdata,
    output logic [N_REQ-1:0]        o_req_done,
    output logic [N_REQ-1:0]        o_req_err,
    output logic [DW-1:0]           o_rdata,
    output logic [1:0]              o_grant_id,
    output logic                    o_busy,
    output logic [AW-1:0]           o_mem_address,
    output logic [1:0]              o_mem_datasize,
    output logic                    o_mem_read,
    output logic                    o_mem_write,
    output logic [DW-1:0]           o_mem_writedata,
    input  logic [DW-1:0]           i_mem_readdata,
    input  logic                    i_mem_done,
    output logic                    o_bus_err,
    input  logic                    i_bus_err_clr
);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t          r_state, w_state_nxt;
    logic [1:0]      r_ptr, r_grant, w_pick, w_idx, w_ptr_adv;
    logic [2:0]      w_sum;
    logic            w_any, w_load, w_done, w_tmo;
    logic [AW-1:0]   r_addr, w_mask;
    logic [1:0]      r_size;
    logic [DW-1:0]   r_wdata;
    logic            r_read, r_write, r_bus_err;
    logic [WDW-1:0]  r_wdog;

    // Rotating-priority pick: first valid requester scanning ptr, ptr+1, ptr+2 (mod 3)
    always_comb begin
        w_any  = 1'b0;
        w_pick = r_ptr;
        w_sum  = '0;
        w_idx  = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            w_sum = 3'(r_ptr) + 3'(k);
            w_idx = (w_sum >= 3'd3) ? 2'(w_sum - 3'd3) : 2'(w_sum);
            if (!w_any && i_req_valid[w_idx]) begin
                w_any  = 1'b1;
                w_pick = w_idx;
            end
        end
    end

    // Alignment mask clears the low size bits of the granted address
    assign w_mask    = ~((AW'(1) << i_req_size[w_pick]) - AW'(1));
    assign w_ptr_adv = (r_grant == 2'd2) ? 2'd0 : r_grant + 2'd1;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next state plus same-cycle completion/abort pulses and load data pass-through
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_done      = 1'b0;
        w_tmo       = 1'b0;
        o_req_done  = '0;
        o_req_err   = '0;
        o_rdata     = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (i_mem_done) begin
                    w_done      = 1'b1;
                    o_req_done  = N_REQ'(3'b001 << r_grant);
                    o_rdata     = i_mem_readdata;
                    w_state_nxt = ST_IDLE;
                end else if (r_wdog == WDW'(TIMEOUT - 1)) begin
                    w_tmo       = 1'b1;
                    o_req_err   = N_REQ'(3'b001 << r_grant);
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Grant capture, strobes, watchdog and priority pointer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr   <= 2'(RESET_PRI);
            r_grant <= '0;
            r_addr  <= '0;
            r_size  <= '0;
            r_wdata <= '0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_wdog  <= '0;
        end else if (w_load) begin
            r_grant <= w_pick;
            r_addr  <= i_req_addr[w_pick] & w_mask;
            r_size  <= i_req_size[w_pick];
            r_wdata <= i_req_wdata[w_pick];
            r_read  <= ~i_req_write[w_pick];
            r_write <= i_req_write[w_pick];
            r_wdog  <= '0;
        end else if (r_state == ST_BUSY) begin
            r_wdog <= r_wdog + WDW'(1);
            if (w_done || w_tmo) begin
                r_read  <= 1'b0;
                r_write <= 1'b0;
                r_ptr   <= w_ptr_adv;
            end
        end
    end

    // Sticky bus error; a new timeout beats a simultaneous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)           r_bus_err <= 1'b0;
        else if (w_tmo)         r_bus_err <= 1'b1;
        else if (i_bus_err_clr) r_bus_err <= 1'b0;
    end

    assign o_grant_id      = r_grant;
    assign o_busy          = (r_state == ST_BUSY);
    assign o_mem_address   = r_addr;
    assign o_mem_datasize  = r_size;
    assign o_mem_read      = r_read;
    assign o_mem_write     = r_write;
    assign o_mem_writedata = r_wdata;
    assign o_bus_err       = r_bus_err;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a queue of expected grants.
module tb_mem_bus_arbiter;

    localparam int TMO = 8;
    localparam logic [63:0] IDLE_RD = 64'hA5A5_5A5A_0F0F_F0F0;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [2:0]       req_valid;
    logic [2:0][63:0] req_addr;
    logic [2:0][1:0]  req_size;
    logic [2:0]       req_write;
    logic [2:0][63:0] req_wdata;
    logic [2:0]       req_done, req_err;
    logic [63:0]      rdata;
    logic [1:0]       grant_id;
    logic             busy;
    logic [63:0]      mem_address;
    logic [1:0]       mem_datasize;
    logic             mem_read, mem_write;
    logic [63:0]      mem_writedata, mem_readdata;
    logic             mem_done;
    logic             bus_err, bus_err_clr;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [1:0]  id;
        logic [63:0] addr;
        logic [1:0]  size;
        logic        wr;
        logic [63:0] wdata;
    } txn_t;

    txn_t sb[$];

    always #5 clk = ~clk;

    mem_bus_arbiter #(.TIMEOUT(TMO), .RESET_PRI(1)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .i_req_valid     (req_valid),
        .i_req_addr      (req_addr),
        .i_req_size      (req_size),
        .i_req_write     (req_write),
        .i_req_wdata     (req_wdata),
        .o_req_done      (req_done),
        .o_req_err       (req_err),
        .o_rdata         (rdata),
        .o_grant_id      (grant_id),
        .o_busy          (busy),
        .o_mem_address   (mem_address),
        .o_mem_datasize  (mem_datasize),
        .o_mem_read      (mem_read),
        .o_mem_write     (mem_write),
        .o_mem_writedata (mem_writedata),
        .i_mem_readdata  (mem_readdata),
        .i_mem_done      (mem_done),
        .o_bus_err       (bus_err),
        .i_bus_err_clr   (bus_err_clr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [63:0] a, input logic [1:0] sz,
                           input logic wr, input logic [63:0] wd);
        req_addr[id]  = a;
        req_size[id]  = sz;
        req_write[id] = wr;
        req_wdata[id] = wd;
        req_valid[id] = 1'b1;
    endtask

    task automatic push(input logic [1:0] id, input logic [63:0] aligned, input logic [1:0] sz,
                        input logic wr, input logic [63:0] wd);
        txn_t t;
        t.id = id; t.addr = aligned; t.size = sz; t.wr = wr; t.wdata = wd;
        sb.push_back(t);
    endtask

    // Wait (bounded) for the first strobe-high cycle; leaves time at negedge+1
    task automatic wait_strobe(output logic seen);
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk); #1;
            if (mem_read || mem_write) begin
                seen = 1'b1;
                break;
            end
        end
        chk("strobe_rise", 64'(seen), 64'd1);
    endtask

    // Pop the expected grant and compare the memory-side request
    task automatic pop_check(output txn_t e);
        e = '0;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_underflow observed=empty expected=entry");
            return;
        end
        e = sb.pop_front();
        chk("grant_id", 64'(grant_id), 64'(e.id));
        chk("mem_address", mem_address, e.addr);
        chk("mem_datasize", 64'(mem_datasize), 64'(e.size));
        chk("mem_read", 64'(mem_read), 64'(!e.wr));
        chk("mem_write", 64'(mem_write), 64'(e.wr));
        if (e.wr) chk("mem_writedata", mem_writedata, e.wdata);
        chk("busy", 64'(busy), 64'd1);
    endtask

    // Memory acks in the lat-th strobe cycle; drop masks requesters the cycle after
    task automatic serve(input int lat, input logic [63:0] rd, input logic [2:0] drop);
        logic seen;
        txn_t e;
        wait_strobe(seen);
        if (!seen) return;
        pop_check(e);
        for (int k = 0; k < lat; k++) begin
            if (k > 0) begin
                @(negedge clk); #1;
                chk("strobe_held", 64'(mem_read | mem_write), 64'd1);
            end
            if (k == lat - 1) begin
                mem_done = 1'b1; mem_readdata = rd; #1;
                chk("req_done", 64'(req_done), 64'(3'b001 << e.id));
                chk("req_err_none", 64'(req_err), 64'd0);
                chk("rdata_done", rdata, rd);
            end else begin
                chk("req_done_early", 64'(req_done), 64'd0);
                chk("rdata_zero", rdata, 64'd0);
            end
        end
        @(posedge clk); #1;
        mem_done = 1'b0; mem_readdata = IDLE_RD;
        req_valid = req_valid & ~drop;
        @(negedge clk); #1;
        chk("strobe_drop", 64'({mem_read, mem_write}), 64'd0);
        chk("busy_drop", 64'(busy), 64'd0);
    endtask

    // Memory never acks; expect abort in the TMO-th strobe cycle
    task automatic expect_timeout(input logic clr_at_err, input logic [2:0] drop);
        logic seen;
        txn_t e;
        wait_strobe(seen);
        if (!seen) return;
        pop_check(e);
        for (int k = 0; k < TMO; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            if (k == TMO - 1) begin
                bus_err_clr = clr_at_err; #1;
                chk("strobe_last", 64'(mem_read | mem_write), 64'd1);
                chk("req_err", 64'(req_err), 64'(3'b001 << e.id));
                chk("req_done_none", 64'(req_done), 64'd0);
            end else begin
                chk("strobe_wait", 64'(mem_read | mem_write), 64'd1);
                chk("req_err_early", 64'(req_err), 64'd0);
            end
        end
        @(posedge clk); #1;
        bus_err_clr = 1'b0;
        req_valid = req_valid & ~drop;
        @(negedge clk); #1;
        chk("strobe_drop_tmo", 64'({mem_read, mem_write}), 64'd0);
        chk("bus_err_set", 64'(bus_err), 64'd1);
    endtask

    task automatic clear_bus_err();
        @(negedge clk); bus_err_clr = 1'b1;
        @(negedge clk); bus_err_clr = 1'b0; #1;
        chk("bus_err_cleared", 64'(bus_err), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time bound exceeded");
    end

    initial begin
        logic seen;
        txn_t e;
        reset_n = 1'b0; req_valid = '0; req_addr = '0; req_size = '0; req_write = '0;
        req_wdata = '0; mem_readdata = IDLE_RD; mem_done = 1'b0; bus_err_clr = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_grant_id", 64'(grant_id), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_strobes", 64'({mem_read, mem_write}), 64'd0);
        chk("rst_address", mem_address, 64'd0);
        chk("rst_datasize", 64'(mem_datasize), 64'd0);
        chk("rst_writedata", mem_writedata, 64'd0);
        chk("rst_bus_err", 64'(bus_err), 64'd0);
        chk("rst_pulses", 64'({req_done, req_err}), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        @(negedge clk); reset_n = 1'b1;

        // mem_done while idle is ignored
        @(negedge clk); mem_done = 1'b1; #1;
        chk("idle_done_ignored", 64'(req_done), 64'd0);
        chk("idle_rdata_zero", rdata, 64'd0);
        @(negedge clk); mem_done = 1'b0; #1;
        chk("idle_stays_idle", 64'(busy), 64'd0);

        // Simultaneous fetch + exec after reset: exec first
        @(negedge clk);
        set_req(0, 64'h0000_0000_0000_1000, 2'd3, 1'b0, 64'd0);
        set_req(1, 64'h0000_0000_0000_2006, 2'd2, 1'b1, 64'h0000_0000_1111_2222);
        push(2'd1, 64'h0000_0000_0000_2004, 2'd2, 1'b1, 64'h0000_0000_1111_2222);
        push(2'd0, 64'h0000_0000_0000_1000, 2'd3, 1'b0, 64'd0);
        serve(2, 64'h0000_0000_0000_1234, 3'b010);
        serve(2, 64'h0000_0000_0000_5678, 3'b001);

        // All three held continuously, one-cycle memory: 1,2,0,1,2,0
        @(negedge clk);
        set_req(0, 64'h0000_0000_0000_0100, 2'd0, 1'b0, 64'd0);
        set_req(1, 64'h0000_0000_0000_0201, 2'd1, 1'b0, 64'd0);
        set_req(2, 64'h0000_0000_0000_030F, 2'd3, 1'b1, 64'h0000_0000_0000_ABCD);
        for (int r = 0; r < 2; r++) begin
            push(2'd1, 64'h0000_0000_0000_0200, 2'd1, 1'b0, 64'd0);
            push(2'd2, 64'h0000_0000_0000_0308, 2'd3, 1'b1, 64'h0000_0000_0000_ABCD);
            push(2'd0, 64'h0000_0000_0000_0100, 2'd0, 1'b0, 64'd0);
        end
        for (int t = 0; t < 6; t++)
            serve(1, 64'h0000_0000_0000_0A00 + 64'(t), (t == 5) ? 3'b111 : 3'b000);

        // Single fetch, tetra aligned down, three-cycle memory
        @(negedge clk);
        set_req(0, 64'h8000_0000_0000_0003, 2'd2, 1'b0, 64'd0);
        push(2'd0, 64'h8000_0000_0000_0000, 2'd2, 1'b0, 64'd0);
        serve(3, 64'hFEED_FACE_0123_4567, 3'b001);

        // Octa store from exec, address aligned, data untouched
        @(negedge clk);
        set_req(1, 64'h0000_0000_4000_0007, 2'd3, 1'b1, 64'hDEAD_BEEF_CAFE_F00D);
        push(2'd1, 64'h0000_0000_4000_0000, 2'd3, 1'b1, 64'hDEAD_BEEF_CAFE_F00D);
        serve(2, 64'd0, 3'b010);

        // Watchdog abort, sticky bus_err, then normal service resumes
        @(negedge clk);
        set_req(2, 64'h0000_0000_0000_9000, 2'd3, 1'b0, 64'd0);
        push(2'd2, 64'h0000_0000_0000_9000, 2'd3, 1'b0, 64'd0);
        expect_timeout(1'b0, 3'b100);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            chk("bus_err_sticky", 64'(bus_err), 64'd1);
        end
        clear_bus_err();
        @(negedge clk);
        set_req(0, 64'h0000_0000_0000_0051, 2'd1, 1'b0, 64'd0);
        push(2'd0, 64'h0000_0000_0000_0050, 2'd1, 1'b0, 64'd0);
        serve(1, 64'h0000_0000_CAFE_0001, 3'b001);

        // Clear in the same cycle as a new timeout: set wins
        @(negedge clk);
        set_req(1, 64'h0000_0000_0000_0060, 2'd0, 1'b1, 64'h0000_0000_0000_0077);
        push(2'd1, 64'h0000_0000_0000_0060, 2'd0, 1'b1, 64'h0000_0000_0000_0077);
        expect_timeout(1'b1, 3'b010);
        clear_bus_err();

        // mem_done in the timeout cycle: done wins, no error
        @(negedge clk);
        set_req(2, 64'h0000_0000_0000_0072, 2'd2, 1'b0, 64'd0);
        push(2'd2, 64'h0000_0000_0000_0070, 2'd2, 1'b0, 64'd0);
        serve(TMO, 64'h0000_0000_0BAD_F00D, 3'b100);
        chk("bus_err_done_wins", 64'(bus_err), 64'd0);

        // Reset mid-transaction drops strobes at once, then priority restarts at 1
        @(negedge clk);
        set_req(0, 64'h0000_0000_0000_0088, 2'd3, 1'b0, 64'd0);
        push(2'd0, 64'h0000_0000_0000_0088, 2'd3, 1'b0, 64'd0);
        wait_strobe(seen);
        pop_check(e);
        reset_n = 1'b0; req_valid = '0; #1;
        chk("rst_mid_strobes", 64'({mem_read, mem_write}), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_pulses", 64'({req_done, req_err}), 64'd0);
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk); #1;
        chk("post_rst_idle", 64'(busy), 64'd0);
        chk("post_rst_no_done", 64'(req_done), 64'd0);
        set_req(0, 64'h0000_0000_0000_0088, 2'd3, 1'b0, 64'd0);
        set_req(1, 64'h0000_0000_0000_00A0, 2'd3, 1'b0, 64'd0);
        set_req(2, 64'h0000_0000_0000_00B0, 2'd3, 1'b0, 64'd0);
        push(2'd1, 64'h0000_0000_0000_00A0, 2'd3, 1'b0, 64'd0);
        serve(1, 64'h0000_0000_0000_00AA, 3'b111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
